// File: rtl/ram_arbiter2.sv
// ram_arbiter2
//   Arbitrates two command masters onto one single-port synchronous RAM.
//   The current owner keeps the RAM for up to MAX_BURST consecutive accepts
//   while the other master is waiting. After that, ownership passes to the
//   other master (round-robin). Read data returns one cycle after the read
//   is accepted, and it goes back to the master that issued the read.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/we/addr/wdata  in    command from master N (held until ready)
//   reqN_ready                out   command from master N accepted this cycle
//   rspN_valid/rdata          out   one-cycle read response to master N
//   ram_cs/we/addr/wdata      out   RAM command port (all zero when idle)
//   ram_rdata                 in    RAM read data, valid the cycle after a read
//
// State table
//   owner   | meaning
//   OWN_0   | master 0 has priority; burst_cnt counts its consecutive accepts
//   OWN_1   | master 1 has priority; burst_cnt counts its consecutive accepts
module ram_arbiter2 #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 2
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Counter must hold the value MAX_BURST itself.
  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  typedef enum logic {
    OWN_0 = 1'b0,
    OWN_1 = 1'b1
  } owner_e;

  owner_e          owner_q, owner_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            pend_vld_q, pend_vld_d;
  owner_e          pend_id_q, pend_id_d;

  owner_e          other_id;
  owner_e          gnt_id;
  logic            owner_vld;
  logic            other_vld;
  logic            burst_full;
  logic            gnt_owner;
  logic            gnt_other;
  logic            gnt_any;
  logic            gnt0;
  logic            gnt1;

  // Grant decision. Gated with rst_n so nothing is granted while reset is held.
  always_comb begin
    other_id   = (owner_q == OWN_0) ? OWN_1 : OWN_0;
    owner_vld  = (owner_q == OWN_0) ? req0_valid : req1_valid;
    other_vld  = (owner_q == OWN_0) ? req1_valid : req0_valid;
    burst_full = (burst_cnt_q == BURST_MAX);

    // Owner yields only when its burst is used up and the other side is waiting.
    gnt_owner  = rst_n & owner_vld & ~(other_vld & burst_full);
    gnt_other  = rst_n & ~gnt_owner & other_vld;
    gnt_any    = gnt_owner | gnt_other;
    gnt_id     = gnt_owner ? owner_q : other_id;

    gnt0       = gnt_any & (gnt_id == OWN_0);
    gnt1       = gnt_any & (gnt_id == OWN_1);
  end

  // RAM command mux.
  always_comb begin
    ram_cs    = gnt_any;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_we    = req0_we;
      ram_addr  = req0_addr;
      ram_wdata = req0_wdata;
    end else if (gnt1) begin
      ram_we    = req1_we;
      ram_addr  = req1_addr;
      ram_wdata = req1_wdata;
    end
  end

  // Next-state: ownership / burst tracking plus the single pending read slot.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    pend_vld_d  = 1'b0;
    pend_id_d   = pend_id_q;

    if (gnt_any) begin
      if (gnt_id == owner_q) begin
        if (!burst_full) begin
          burst_cnt_d = burst_cnt_q + BURST_ONE;
        end
      end else begin
        owner_d     = gnt_id;
        burst_cnt_d = BURST_ONE;
      end
      pend_vld_d = ~ram_we;
      pend_id_d  = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_0;
      burst_cnt_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_id_q   <= OWN_0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_id_q   <= pend_id_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Read data comes straight from the RAM in the response cycle; zeroed otherwise.
  assign rsp0_valid = pend_vld_q & (pend_id_q == OWN_0);
  assign rsp1_valid = pend_vld_q & (pend_id_q == OWN_1);
  assign rsp0_rdata = rsp0_valid ? ram_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? ram_rdata : '0;

endmodule
